// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock tick scheduler.
//   ch_state_e  : per-channel state (ST_IDLE / ST_RUN)
//   DEFAULT_PSC : default base prescaler ratio
//   clog2_min1  : ceil(log2(n)), never less than 1 (safe vector width)
package clock_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam int unsigned DEFAULT_PSC = 100;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clock_prescaler.sv
// Base prescaler: free-running counter 0..PSC-1 with a registered one-cycle
// strobe each time the counter wraps.
//   clk_i       : system clock
//   rst_ni      : asynchronous active-low reset
//   base_tick_o : strobe, high one cycle in every PSC (constant high if PSC == 1)
module clock_prescaler
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned PSC = DEFAULT_PSC
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic base_tick_o
);

    localparam int unsigned    CNT_W = clog2_min1(PSC);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PSC - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            base_tick_o <= 1'b0;
        end else if (cnt_q == LAST) begin
            cnt_q       <= '0;
            base_tick_o <= 1'b1;
        end else begin
            cnt_q       <= cnt_q + CNT_W'(1);
            base_tick_o <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_tick_scheduler.sv
// Clock tick scheduler: one shared base prescaler feeding N_CH channels, each
// emitting a one-cycle enable tick every div base ticks. Channels are
// configured through a valid/ready port; a rewrite of a running channel is
// held in a shadow register and applied at the next period boundary.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   cfg_valid_i   : config write request
//   cfg_ready_o   : write accepted this cycle if also valid (low while pending)
//   cfg_ch_i      : target channel (out-of-range channels are accepted, dropped)
//   cfg_div_i     : divide value in base ticks (0 treated as 1)
//   cfg_en_i      : channel enable
//   base_tick_o   : base prescaler strobe
//   tick_o        : per-channel tick, coincident with the completing base tick
//   active_o      : channel running
module clock_tick_scheduler
    import clock_ctrl_pkg::*;
#(
    parameter  int unsigned PSC   = DEFAULT_PSC,
    parameter  int unsigned N_CH  = 4,
    parameter  int unsigned DIV_W = 16,
    localparam int unsigned CH_W  = clog2_min1(N_CH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [CH_W-1:0]  cfg_ch_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    input  logic             cfg_en_i,
    output logic             base_tick_o,
    output logic [N_CH-1:0]  tick_o,
    output logic [N_CH-1:0]  active_o
);

    logic                 base_tick;
    logic [N_CH-1:0]      pending;
    logic [2**CH_W-1:0]   pending_ext;
    logic                 cfg_accept;
    logic [DIV_W-1:0]     eff_div;

    clock_prescaler #(
        .PSC (PSC)
    ) u_prescaler (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .base_tick_o (base_tick)
    );

    assign base_tick_o = base_tick;

    // Pad to the full channel address space so out-of-range channels read
    // as never pending (always ready, then discarded).
    always_comb begin
        pending_ext           = '0;
        pending_ext[N_CH-1:0] = pending;
    end

    assign cfg_ready_o = ~pending_ext[cfg_ch_i];
    assign cfg_accept  = cfg_valid_i & cfg_ready_o;
    assign eff_div     = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ch_state_e        state_q;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] shadow_q;
        logic             pend_q;
        logic             sel;
        logic             at_last;

        assign sel     = cfg_accept && (cfg_ch_i == CH_W'(g));
        assign at_last = (cnt_q == div_q - DIV_W'(1));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= ST_IDLE;
                div_q    <= '0;
                cnt_q    <= '0;
                shadow_q <= '0;
                pend_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        // A base tick in the acceptance cycle is not counted.
                        if (sel && cfg_en_i) begin
                            div_q   <= eff_div;
                            cnt_q   <= '0;
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (sel && !cfg_en_i) begin
                            state_q <= ST_IDLE;
                            cnt_q   <= '0;
                            pend_q  <= 1'b0;
                        end else begin
                            if (base_tick) begin
                                if (at_last) begin
                                    cnt_q <= '0;
                                    if (pend_q) begin
                                        div_q  <= shadow_q;
                                        pend_q <= 1'b0;
                                    end
                                end else begin
                                    cnt_q <= cnt_q + DIV_W'(1);
                                end
                            end
                            // Accept implies pend_q was 0, so a coincident
                            // boundary used the old div and this write waits
                            // for the following boundary.
                            if (sel && cfg_en_i) begin
                                shadow_q <= eff_div;
                                pend_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end

        assign pending[g]  = pend_q;
        assign active_o[g] = (state_q == ST_RUN);
        assign tick_o[g]   = base_tick & (state_q == ST_RUN) & at_last;
    end

endmodule

// File: tb/tb_clock_tick_scheduler.sv
module tb_clock_tick_scheduler;

    localparam int unsigned PSC   = 4;
    localparam int unsigned N_CH  = 2;
    localparam int unsigned DIV_W = 8;

    logic             clk_i;
    logic             rst_ni;
    logic             cfg_valid_i;
    logic             cfg_ready_o;
    logic [0:0]       cfg_ch_i;
    logic [DIV_W-1:0] cfg_div_i;
    logic             cfg_en_i;
    logic             base_tick_o;
    logic [N_CH-1:0]  tick_o;
    logic [N_CH-1:0]  active_o;

    clock_tick_scheduler #(
        .PSC   (PSC),
        .N_CH  (N_CH),
        .DIV_W (DIV_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_ch_i    (cfg_ch_i),
        .cfg_div_i   (cfg_div_i),
        .cfg_en_i    (cfg_en_i),
        .base_tick_o (base_tick_o),
        .tick_o      (tick_o),
        .active_o    (active_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Reference model: absolute base-tick indices. Base tick k occurs in
    // cycle k*PSC after reset release; each running channel remembers the
    // index of its next tick.
    int  cyc;
    bit  m_run  [N_CH];
    bit  m_pend [N_CH];
    int  m_div  [N_CH];
    int  m_sh   [N_CH];
    int  m_nxt  [N_CH];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit m_base(input int c);
        return (c > 0) && (c % PSC == 0);
    endfunction

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_run[i] = 0; m_pend[i] = 0; m_div[i] = 0; m_sh[i] = 0; m_nxt[i] = 0;
        end
    endtask

    task automatic model_edge(input logic v, input int ch, input int d, input logic e,
                              input bit rdy);
        int c_prev;
        int eff;
        c_prev = cyc;
        for (int i = 0; i < N_CH; i++) begin
            if (m_run[i] && m_base(c_prev) && (c_prev / PSC == m_nxt[i])) begin
                if (m_pend[i]) begin
                    m_div[i]  = m_sh[i];
                    m_pend[i] = 0;
                end
                m_nxt[i] = m_nxt[i] + m_div[i];
            end
        end
        if (v && rdy && ch < N_CH) begin
            eff = (d == 0) ? 1 : d;
            if (!e) begin
                m_run[ch]  = 0;
                m_pend[ch] = 0;
            end else if (!m_run[ch]) begin
                m_run[ch] = 1;
                m_div[ch] = eff;
                m_nxt[ch] = (c_prev + 1 + PSC - 1) / PSC + eff - 1;
            end else begin
                m_sh[ch]   = eff;
                m_pend[ch] = 1;
            end
        end
        cyc = c_prev + 1;
    endtask

    // One clock cycle: drive inputs, check outputs for the current cycle,
    // then advance DUT and model across the rising edge.
    task automatic cycle(input logic v, input int ch, input int d, input logic e);
        bit rdy;
        bit b;
        cfg_valid_i = v;
        cfg_ch_i    = ch[0:0];
        cfg_div_i   = DIV_W'(d);
        cfg_en_i    = e;
        #1;
        b   = m_base(cyc);
        rdy = !m_pend[ch];
        check_bit("base_tick", base_tick_o, b);
        check_bit("cfg_ready", cfg_ready_o, rdy);
        for (int i = 0; i < N_CH; i++) begin
            check_bit($sformatf("active[%0d]", i), active_o[i], m_run[i]);
            check_bit($sformatf("tick[%0d]", i), tick_o[i],
                      b && m_run[i] && (cyc / PSC == m_nxt[i]));
        end
        @(posedge clk_i);
        model_edge(v, ch, d, e, rdy);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_ch_i    = '0;
        cfg_div_i   = '0;
        cfg_en_i    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // 1: free-running prescaler, no channels
        idle(13);

        // 2: ch0 div=3
        cycle(1'b1, 0, 3, 1'b1);
        idle(40);

        // 3: rewrite ch0 mid-period, stalled second write, ch1 accepted
        idle(5);
        cycle(1'b1, 0, 2, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, int'($urandom_range(1, 5)), 1'b1);
        cycle(1'b1, 1, 5, 1'b1);
        idle(40);

        // 4: stop ch0 mid-period, then re-enable with div=1
        idle(3);
        cycle(1'b1, 0, 7, 1'b0);
        idle(20);
        cycle(1'b1, 0, 1, 1'b1);
        idle(20);

        // 5: ch1 div=0 behaves as div=1
        cycle(1'b1, 1, 0, 1'b0);
        idle(2);
        cycle(1'b1, 1, 0, 1'b1);
        idle(20);

        // Randomised writes
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                cycle(1'b1, int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                      $urandom_range(0, 4) != 0);
            else
                idle(1);
        end

        // 6: asynchronous reset mid-run, with both channels enabled at div=1
        cycle(1'b1, 0, 1, 1'b1);
        cycle(1'b1, 1, 1, 1'b1);
        idle(2);
        #2;
        rst_ni = 1'b0;
        #1;
        check_bit("rst_base_tick", base_tick_o, 1'b0);
        for (int i = 0; i < N_CH; i++) begin
            check_bit($sformatf("rst_active[%0d]", i), active_o[i], 1'b0);
            check_bit($sformatf("rst_tick[%0d]", i), tick_o[i], 1'b0);
        end
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
        idle(14);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
